// File: rtl/fpa_sched_pkg.sv
// Shared definitions for the FP operation scheduler: op codes, FSM states,
// IEEE-754 single constants and the result classification helper.
package fpa_sched_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [31:0] FP_CANON_NAN = 32'h7FFF_FFFF;
    localparam logic [7:0]  FP_EXP_MAX   = 8'hFF;

    // {nan, inf, zero} from the exponent/mantissa fields; sign plays no part.
    function automatic logic [2:0] fp_flags(input logic [30:0] mag);
        fp_flags[2] = (mag[30:23] == FP_EXP_MAX) && (mag[22:0] != 23'h0);
        fp_flags[1] = (mag[30:23] == FP_EXP_MAX) && (mag[22:0] == 23'h0);
        fp_flags[0] = (mag[30:23] == 8'h00);
    endfunction

endpackage

// File: rtl/fpa_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or above
// ptr_i (wrapping) that has its request bit set.
module fpa_rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  grant_idx_o,
    output logic            grant_valid_o
);

    int idx;

    // Scan from the farthest offset down so the closest valid requester wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        grant_o       = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        idx           = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr_i) + k) % NREQ;
            if (req_i[idx]) begin
                grant_o       = '0;
                grant_o[idx]  = 1'b1;
                grant_idx_o   = IDW'(idx);
                grant_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpa_unit.sv
// Combinational single-precision add/sub/mul/div. Denormal inputs and results
// flush to +0, rounding truncates, overflow saturates to signed infinity and
// every invalid case (including x/0) returns the canonical NaN.
module fpa_unit
    import fpa_sched_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [1:0]  op_i,
    output logic [31:0] y_o
);

    // Normalise a magnitude whose unit bit nominally sits at bit 47, then pack.
    function automatic logic [31:0] pack(input logic s, input logic signed [11:0] e,
                                         input logic [49:0] v);
        logic [5:0]         p;
        logic [49:0]        n;
        logic signed [11:0] en;
        p = 6'd0;
        for (int i = 0; i < 50; i++) begin
            if (v[i]) p = 6'(i);
        end
        if (p >= 6'd47) begin
            n  = v >> (p - 6'd47);
            en = e + $signed(12'(p - 6'd47));
        end else begin
            n  = v << (6'd47 - p);
            en = e - $signed(12'(6'd47 - p));
        end
        if (v == '0 || en <= 12'sd0) pack = 32'h0;
        else if (en >= 12'sd255)     pack = {s, FP_EXP_MAX, 23'h0};
        else                         pack = {s, en[7:0], n[46:24]};
    endfunction

    logic        sa, sb;
    logic [7:0]  ea, eb;
    logic [23:0] ma, mb;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic        a_big, s_big, s_sml;
    logic [7:0]  e_big, e_sml, e_dif;
    logic [23:0] m_big, m_sml;
    logic [49:0] v_big, v_sml, v_add;
    logic [47:0] prod;
    logic [49:0] quot;
    logic [31:0] add_y, mul_y, div_y;

    assign sa     = a_i[31];
    assign sb     = b_i[31] ^ (op_i == OP_SUB);
    assign ea     = a_i[30:23];
    assign eb     = b_i[30:23];
    assign ma     = {1'b1, a_i[22:0]};
    assign mb     = {1'b1, b_i[22:0]};
    assign a_zero = (ea == 8'h00);
    assign b_zero = (eb == 8'h00);
    assign a_inf  = (ea == FP_EXP_MAX) && (a_i[22:0] == 23'h0);
    assign b_inf  = (eb == FP_EXP_MAX) && (b_i[22:0] == 23'h0);
    assign a_nan  = (ea == FP_EXP_MAX) && (a_i[22:0] != 23'h0);
    assign b_nan  = (eb == FP_EXP_MAX) && (b_i[22:0] != 23'h0);

    // Add/sub: align the smaller magnitude under the larger, then add or subtract.
    always_comb begin
        a_big = (a_i[30:0] >= b_i[30:0]);
        s_big = a_big ? sa : sb;
        s_sml = a_big ? sb : sa;
        e_big = a_big ? ea : eb;
        e_sml = a_big ? eb : ea;
        m_big = a_big ? ma : mb;
        m_sml = a_big ? mb : ma;
        e_dif = e_big - e_sml;
        v_big = {2'b00, m_big, 24'h0};
        v_sml = {2'b00, m_sml, 24'h0} >> e_dif;
        v_add = (s_big == s_sml) ? v_big + v_sml : v_big - v_sml;
        add_y = pack(s_big, $signed({4'h0, e_big}), v_add);
    end

    assign prod  = ma * mb;
    assign quot  = {ma, 26'h0} / {26'h0, mb};
    assign mul_y = pack(sa ^ sb, $signed({4'h0, ea}) + $signed({4'h0, eb}) - 12'sd126,
                        {2'b00, prod});
    assign div_y = pack(sa ^ sb, $signed({4'h0, ea}) - $signed({4'h0, eb}) + 12'sd127,
                        quot << 21);

    // Special operands take priority over the arithmetic paths.
    always_comb begin
        y_o = 32'h0;
        case (op_i)
            OP_ADD, OP_SUB: begin
                if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) y_o = FP_CANON_NAN;
                else if (a_inf)             y_o = {sa, FP_EXP_MAX, 23'h0};
                else if (b_inf)             y_o = {sb, FP_EXP_MAX, 23'h0};
                else if (a_zero && b_zero)  y_o = 32'h0;
                else if (a_zero)            y_o = {sb, b_i[30:0]};
                else if (b_zero)            y_o = a_i;
                else                        y_o = add_y;
            end
            OP_MUL: begin
                if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) y_o = FP_CANON_NAN;
                else if (a_inf || b_inf)    y_o = {sa ^ sb, FP_EXP_MAX, 23'h0};
                else if (a_zero || b_zero)  y_o = 32'h0;
                else                        y_o = mul_y;
            end
            OP_DIV: begin
                if (a_nan || b_nan || b_zero || (a_inf && b_inf)) y_o = FP_CANON_NAN;
                else if (a_inf)             y_o = {sa ^ sb, FP_EXP_MAX, 23'h0};
                else if (b_inf || a_zero)   y_o = 32'h0;
                else                        y_o = div_y;
            end
            default: y_o = FP_CANON_NAN;
        endcase
    end

endmodule

// File: rtl/fpa_op_scheduler.sv
// Shares one combinational FP unit between NREQ requesters: round-robin
// accept, operand registers, a fixed settle window, registered response.
module fpa_op_scheduler
    import fpa_sched_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int IDW         = 1,
    parameter int WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid_i,
    output logic [NREQ-1:0]    req_ready_o,
    input  logic [NREQ*32-1:0] req_n1_i,
    input  logic [NREQ*32-1:0] req_n2_i,
    input  logic [NREQ*2-1:0]  req_op_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [IDW-1:0]     rsp_id_o,
    output logic [31:0]        rsp_result_o,
    output logic [2:0]         rsp_flags_o,
    output logic               busy_o
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [31:0]     n1_q, n1_d, n2_q, n2_d;
    logic [1:0]      op_q, op_d;
    logic [IDW-1:0]  id_q, id_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [31:0]     rsp_result_q, rsp_result_d;
    logic [2:0]      rsp_flags_q, rsp_flags_d;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            grant_valid;
    logic [31:0]     fpu_y;

    fpa_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req_i         (req_valid_i),
        .ptr_i         (ptr_q),
        .grant_o       (grant),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_valid)
    );

    // Fed only from the operand registers, so its inputs hold for the whole window.
    fpa_unit u_fpu (
        .a_i  (n1_q),
        .b_i  (n2_q),
        .op_i (op_q),
        .y_o  (fpu_y)
    );

    // Next-state and handshake logic for IDLE -> WAIT -> DONE -> IDLE.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ptr_d        = ptr_q;
        n1_d         = n1_q;
        n2_d         = n2_q;
        op_d         = op_q;
        id_d         = id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        req_ready_o  = '0;
        case (state_q)
            S_IDLE: begin
                req_ready_o = rst ? '0 : grant;
                if (grant_valid) begin
                    n1_d    = req_n1_i[32*grant_idx +: 32];
                    n2_d    = req_n2_i[32*grant_idx +: 32];
                    op_d    = req_op_i[2*grant_idx +: 2];
                    id_d    = grant_idx;
                    cnt_d   = CW'(WAIT_CYCLES - 1);
                    ptr_d   = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    rsp_result_d = fpu_y;
                    rsp_flags_d  = fp_flags(fpu_y[30:0]);
                    rsp_id_d     = id_q;
                    rsp_valid_d  = 1'b1;
                    state_d      = S_DONE;
                end
            end
            S_DONE: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register with synchronous reset; reset discards any in-flight op.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            ptr_q        <= '0;
            n1_q         <= '0;
            n2_q         <= '0;
            op_q         <= '0;
            id_q         <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ptr_q        <= ptr_d;
            n1_q         <= n1_d;
            n2_q         <= n2_d;
            op_q         <= op_d;
            id_q         <= id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
        end
    end

    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_id_o     = rsp_id_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_flags_o  = rsp_flags_q;
    assign busy_o       = (state_q != S_IDLE);

endmodule
